// File: rtl/dram_split_access_ctrl.sv
// CPU-side front end to the SDRAM controller: splits unaligned 1/2/4/8-byte accesses
// into one or two aligned DATA_W transactions. Define DRAM_REFRESH_EN to add refresh scheduling.
module dram_split_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REFRESH_CNT = 200,
  parameter int REFRESH_MAX = 405
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [2:0]            i_ctrl,
  output logic                  o_ack,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_busy,
  output logic [7:0]            o_state,
  output logic                  o_m_rd,
  output logic                  o_m_wr,
  output logic                  o_m_refresh,
  output logic [ADDR_W-1:0]     o_m_addr,
  output logic [DATA_W-1:0]     o_m_wdata,
  output logic [DATA_W/8-1:0]   o_m_mask,
  input  logic [DATA_W-1:0]     i_m_rdata,
  input  logic                  i_m_busy,
  output logic                  o_late_refresh
);
  localparam int B    = DATA_W / 8;
  localparam int B2   = 2 * B;
  localparam int OFFW = $clog2(B);

  typedef enum logic [3:0] {
    S_IDLE, S_RD1_REQ, S_RD1_WAIT, S_RD2_REQ, S_RD2_WAIT, S_WR1_REQ, S_WR1_WAIT,
    S_WR2_REQ, S_WR2_WAIT, S_DONE, S_REF_REQ, S_REF_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d, rd1_q, rd1_d, odata_q, odata_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                err_q, err_d, ack_q, ack_d;
  logic                ref_force, ref_want, accept, illegal_in;

  assign illegal_in = (DATA_W == 32) && (i_ctrl[1:0] == 2'd3);

`ifdef DRAM_REFRESH_EN
  logic [31:0] rcnt_q, rcnt_d;
  logic        late_q, late_d;
  assign ref_force = rcnt_q > 32'(REFRESH_MAX);
  assign ref_want  = rcnt_q > 32'(REFRESH_CNT);
  always_comb begin
    rcnt_d = rcnt_q + 32'd1;
    if (state_q == S_REF_WAIT && !i_m_busy) rcnt_d = '0;
    late_d = late_q | (state_q == S_IDLE && state_d == S_REF_REQ && ref_force);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      late_q <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      late_q <= late_d;
    end
  end
  assign o_late_refresh = late_q;
`else
  logic unused_ref;
  assign unused_ref     = ^{REFRESH_CNT, REFRESH_MAX};
  assign ref_force      = 1'b0;
  assign ref_want       = 1'b0;
  assign o_late_refresh = 1'b0;
`endif

  // Access geometry, all derived from the captured request
  logic [OFFW-1:0]     off;
  logic [3:0]          nbytes;
  logic [4:0]          endb;
  logic                split, second;
  logic [B2-1:0]       bm, mfull;
  logic [2*DATA_W-1:0] wfull;
  logic [ADDR_W-1:0]   wa;

  assign off    = addr_q[OFFW-1:0];
  assign nbytes = 4'd1 << ctrl_q[1:0];
  assign endb   = 5'(off) + 5'(nbytes);
  assign split  = endb > 5'(B);
  assign bm     = (B2'(1) << nbytes) - B2'(1);
  assign mfull  = bm << off;
  assign wfull  = {{DATA_W{1'b0}}, data_q} << {off, 3'b000};
  assign wa     = addr_q & ~ADDR_W'(B - 1);
  assign second = state_q inside {S_RD2_REQ, S_RD2_WAIT, S_WR2_REQ, S_WR2_WAIT};

  // Load result: {rd2, rd1} shifted down, then sign/zero extended from the access width
  logic [DATA_W-1:0] rd_lo, rd_hi, sh, lowmask, topbit, load_res;
  logic [6:0]        nbits;
  logic              sgn;

  assign rd_lo    = (state_q == S_RD2_WAIT) ? rd1_q : i_m_rdata;
  assign rd_hi    = (state_q == S_RD2_WAIT) ? i_m_rdata : '0;
  assign sh       = DATA_W'({rd_hi, rd_lo} >> {off, 3'b000});
  assign nbits    = 7'd8 << ctrl_q[1:0];
  assign lowmask  = (DATA_W'(1) << nbits) - DATA_W'(1);
  assign topbit   = lowmask & ~(lowmask >> 1);
  assign sgn      = !ctrl_q[2] && (ctrl_q[1:0] != 2'd3) && |(sh & topbit);
  assign load_res = (sh & lowmask) | (sgn ? ~lowmask : '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!i_m_busy) begin
        if (ref_force)                state_d = S_REF_REQ;
        else if (i_rd_en || i_wr_en)  state_d = illegal_in ? S_DONE : (i_rd_en ? S_RD1_REQ : S_WR1_REQ);
        else if (ref_want)            state_d = S_REF_REQ;
      end
      S_RD1_REQ:  if (i_m_busy)  state_d = S_RD1_WAIT;
      S_RD1_WAIT: if (!i_m_busy) state_d = split ? S_RD2_REQ : S_DONE;
      S_RD2_REQ:  if (i_m_busy)  state_d = S_RD2_WAIT;
      S_RD2_WAIT: if (!i_m_busy) state_d = S_DONE;
      S_WR1_REQ:  if (i_m_busy)  state_d = S_WR1_WAIT;
      S_WR1_WAIT: if (!i_m_busy) state_d = split ? S_WR2_REQ : S_DONE;
      S_WR2_REQ:  if (i_m_busy)  state_d = S_WR2_WAIT;
      S_WR2_WAIT: if (!i_m_busy) state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      S_REF_REQ:  if (i_m_busy)  state_d = S_REF_WAIT;
      S_REF_WAIT: if (!i_m_busy) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) && (state_d inside {S_RD1_REQ, S_WR1_REQ, S_DONE});

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    rd1_d   = rd1_q;
    odata_d = odata_q;
    ack_d   = accept;
    if (accept) begin
      addr_d = i_addr;
      data_d = i_data;
      ctrl_d = i_ctrl;
      err_d  = illegal_in;
    end
    if (state_q == S_RD1_WAIT && !i_m_busy) rd1_d = i_m_rdata;
    if (state_q == S_IDLE && state_d == S_DONE) odata_d = '0;
    else if ((state_q == S_RD1_WAIT || state_q == S_RD2_WAIT) && state_d == S_DONE) odata_d = load_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      rd1_q   <= '0;
      odata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      rd1_q   <= rd1_d;
      odata_q <= odata_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    o_m_rd    = state_q inside {S_RD1_REQ, S_RD2_REQ};
    o_m_wr    = state_q inside {S_WR1_REQ, S_WR2_REQ};
`ifdef DRAM_REFRESH_EN
    o_m_refresh = (state_q == S_REF_REQ);
`else
    o_m_refresh = 1'b0;
`endif
    o_m_addr  = second ? wa + ADDR_W'(B) : wa;
    o_m_wdata = second ? wfull[2*DATA_W-1:DATA_W] : wfull[DATA_W-1:0];
    o_m_mask  = '0;
    if (o_m_rd || o_m_wr) o_m_mask = second ? mfull[B2-1:B] : mfull[B-1:0];
    o_ack     = ack_q;
    o_done    = (state_q == S_DONE);
    o_err     = (state_q == S_DONE) && err_q;
    o_data    = odata_q;
    o_busy    = (state_q != S_IDLE) || i_m_busy;
    o_state   = 8'(state_q);
  end
endmodule

// File: tb/tb_dram_split_access_ctrl.sv
// Directed bench for dram_split_access_ctrl: 32-bit and 64-bit instances, each with a
// small busy/latency backend memory model.
module tb_dram_split_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, preload;
  logic        rd32, wr32, rd64, wr64;
  logic [31:0] i_addr;
  logic [63:0] i_data;
  logic [2:0]  i_ctrl;

  logic        ack32, done32, err32, busy32, mrd32, mwr32, mref32, late32;
  logic [31:0] odata32, maddr32, mwd32, mrdata32;
  logic [7:0]  st32;
  logic [3:0]  mmask32;
  logic        mbusy32 = 1'b0;

  logic        ack64, done64, err64, busy64, mrd64, mwr64, mref64, late64;
  logic [63:0] odata64, mwd64, mrdata64;
  logic [31:0] maddr64;
  logic [7:0]  st64, mmask64;
  logic        mbusy64 = 1'b0;

  dram_split_access_ctrl #(.DATA_W(32), .ADDR_W(32), .REFRESH_CNT(20), .REFRESH_MAX(40)) u32 (
    .clk(clk), .rst(rst), .i_rd_en(rd32), .i_wr_en(wr32), .i_addr(i_addr), .i_data(i_data[31:0]),
    .i_ctrl(i_ctrl), .o_ack(ack32), .o_done(done32), .o_err(err32), .o_data(odata32),
    .o_busy(busy32), .o_state(st32), .o_m_rd(mrd32), .o_m_wr(mwr32), .o_m_refresh(mref32),
    .o_m_addr(maddr32), .o_m_wdata(mwd32), .o_m_mask(mmask32), .i_m_rdata(mrdata32),
    .i_m_busy(mbusy32), .o_late_refresh(late32));

  dram_split_access_ctrl #(.DATA_W(64), .ADDR_W(32), .REFRESH_CNT(20), .REFRESH_MAX(40)) u64 (
    .clk(clk), .rst(rst), .i_rd_en(rd64), .i_wr_en(wr64), .i_addr(i_addr), .i_data(i_data),
    .i_ctrl(i_ctrl), .o_ack(ack64), .o_done(done64), .o_err(err64), .o_data(odata64),
    .o_busy(busy64), .o_state(st64), .o_m_rd(mrd64), .o_m_wr(mwr64), .o_m_refresh(mref64),
    .o_m_addr(maddr64), .o_m_wdata(mwd64), .o_m_mask(mmask64), .i_m_rdata(mrdata64),
    .i_m_busy(mbusy64), .o_late_refresh(late64));

  // Backend models: busy rises the cycle after a request and stays up for 2 cycles
  logic [31:0] mem32 [0:255];
  logic [63:0] mem64 [0:255];
  int cnt32 = 0, cnt64 = 0, nrd32 = 0, nwr32 = 0, nrd64 = 0, nwr64 = 0;
  logic [31:0] la32 [2];
  logic [31:0] ld32 [2];
  logic [3:0]  lm32 [2];
  logic [7:0]  lm64 [2];

  always @(posedge clk) begin
    if (preload) begin
      mem32[0] <= 32'h44332211; mem32[1] <= 32'h88776655; mem32[2] <= 32'h0;
    end else if (mbusy32) begin
      if (cnt32 == 1) mbusy32 <= 1'b0;
      cnt32 <= cnt32 - 1;
    end else if (mrd32 || mwr32 || mref32) begin
      mbusy32 <= 1'b1; cnt32 <= 2;
      if (mrd32) begin nrd32 <= nrd32 + 1; mrdata32 <= mem32[maddr32[9:2]]; end
      if (mwr32) begin
        nwr32 <= nwr32 + 1;
        for (int b = 0; b < 4; b++) if (mmask32[b]) mem32[maddr32[9:2]][8*b +: 8] <= mwd32[8*b +: 8];
        la32[0] <= la32[1]; la32[1] <= maddr32;
        ld32[0] <= ld32[1]; ld32[1] <= mwd32;
        lm32[0] <= lm32[1]; lm32[1] <= mmask32;
      end
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      mem64[0] <= 64'h0; mem64[1] <= 64'h0;
    end else if (mbusy64) begin
      if (cnt64 == 1) mbusy64 <= 1'b0;
      cnt64 <= cnt64 - 1;
    end else if (mrd64 || mwr64 || mref64) begin
      mbusy64 <= 1'b1; cnt64 <= 2;
      if (mrd64) begin nrd64 <= nrd64 + 1; mrdata64 <= mem64[maddr64[10:3]]; end
      if (mwr64) begin
        nwr64 <= nwr64 + 1;
        for (int b = 0; b < 8; b++) if (mmask64[b]) mem64[maddr64[10:3]][8*b +: 8] <= mwd64[8*b +: 8];
        lm64[0] <= lm64[1]; lm64[1] <= mmask64;
      end
    end
  end

  int nack32 = 0, ndone32 = 0, nerr32 = 0, nack64 = 0, ndone64 = 0, nrefobs = 0;
  always @(negedge clk) begin
    if (ack32) nack32++;
    if (done32) ndone32++;
    if (done32 && err32) nerr32++;
    if (ack64) nack64++;
    if (done64) ndone64++;
    if (mref32 || mref64) nrefobs++;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Raise an enable at a falling edge, hold it until o_ack, then wait for o_done.
  task automatic req(input bit sel, input logic wr, input logic both, input logic [2:0] ctrl,
                     input logic [31:0] a, input logic [63:0] d, output int lat, output bit acked);
    @(negedge clk);
    i_addr = a; i_ctrl = ctrl; i_data = d;
    if (sel) begin rd64 = !wr || both; wr64 = wr; end
    else     begin rd32 = !wr || both; wr32 = wr; end
    acked = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sel ? ack64 : ack32) == 1'b1) begin acked = 1'b1; break; end
    end
    rd32 = 0; wr32 = 0; rd64 = 0; wr64 = 0;
    lat = 0;
    while (!(sel ? done64 : done32) && lat < 60) begin @(negedge clk); lat++; end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic        both;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_rd;
    int          exp_wr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t tv [NV];
  int lat, s_rd, s_wr, s_ack, s_done, s_err, s_ack0, exp_lat;
  bit acked, seen;

  initial begin
    rst = 1; preload = 1; rd32 = 0; wr32 = 0; rd64 = 0; wr64 = 0;
    i_addr = '0; i_data = '0; i_ctrl = '0;
    repeat (3) @(negedge clk);
    rst = 0; preload = 0;
    @(negedge clk);
    chk("rst_state", st32, 8'd0);
    chk("rst_ack", ack32, 0);
    chk("rst_done", done32, 0);
    chk("rst_err", err32, 0);
    chk("rst_req", {mrd32, mwr32, mref32}, 0);
    chk("rst_mask", mmask32, 0);
    chk("rst_data32", odata32, 0);
    chk("rst_data64", odata64, 0);
    chk("rst_late", late32, 0);
    chk("rst_busy", busy32, 0);

    //        wr both ctrl  addr          wdata         exp_data      rd wr err
    tv[0]  = '{0, 0, 3'd2, 32'h1003, 32'h0,        32'h77665544, 2, 0, 0};
    tv[1]  = '{0, 0, 3'd1, 32'h1002, 32'h0,        32'h00004433, 1, 0, 0};
    tv[2]  = '{0, 0, 3'd1, 32'h1007, 32'h0,        32'h00000088, 2, 0, 0};
    tv[3]  = '{1, 0, 3'd0, 32'h1001, 32'h80,       32'h00000088, 0, 1, 0};
    tv[4]  = '{0, 0, 3'd0, 32'h1001, 32'h0,        32'hFFFFFF80, 1, 0, 0};
    tv[5]  = '{0, 0, 3'd4, 32'h1001, 32'h0,        32'h00000080, 1, 0, 0};
    tv[6]  = '{1, 0, 3'd2, 32'h1002, 32'hAABBCCDD, 32'h00000080, 0, 2, 0};
    tv[7]  = '{0, 0, 3'd2, 32'h1002, 32'h0,        32'hAABBCCDD, 2, 0, 0};
    tv[8]  = '{0, 0, 3'd1, 32'h1003, 32'h0,        32'hFFFFBBCC, 2, 0, 0};
    tv[9]  = '{0, 0, 3'd3, 32'h1000, 32'h0,        32'h00000000, 0, 0, 1};
    tv[10] = '{0, 0, 3'd2, 32'h1000, 32'h0,        32'hCCDD8011, 1, 0, 0};
    tv[11] = '{1, 0, 3'd1, 32'h1006, 32'h1234,     32'hCCDD8011, 0, 1, 0};
    tv[12] = '{0, 0, 3'd6, 32'h1004, 32'h0,        32'h1234AABB, 1, 0, 0};
    tv[13] = '{1, 0, 3'd3, 32'h1000, 32'h0,        32'h00000000, 0, 0, 1};
    tv[14] = '{0, 0, 3'd4, 32'h1007, 32'h0,        32'h00000012, 1, 0, 0};
    tv[15] = '{1, 1, 3'd2, 32'h1004, 32'h55555555, 32'h1234AABB, 1, 0, 0};

    for (int k = 0; k < NV; k++) begin
      s_rd = nrd32; s_wr = nwr32; s_ack = nack32; s_done = ndone32; s_err = nerr32;
      req(0, tv[k].wr, tv[k].both, tv[k].ctrl, tv[k].addr, {32'h0, tv[k].wdata}, lat, acked);
      exp_lat = tv[k].exp_err ? 0 : 4 * (tv[k].exp_rd + tv[k].exp_wr);
      chk($sformatf("v%0d_acked", k), acked, 1);
      chk($sformatf("v%0d_data", k), odata32, tv[k].exp_data);
      chk($sformatf("v%0d_nrd", k), nrd32 - s_rd, tv[k].exp_rd);
      chk($sformatf("v%0d_nwr", k), nwr32 - s_wr, tv[k].exp_wr);
      chk($sformatf("v%0d_err", k), nerr32 - s_err, tv[k].exp_err);
      chk($sformatf("v%0d_nack", k), nack32 - s_ack, 1);
      chk($sformatf("v%0d_ndone", k), ndone32 - s_done, 1);
      chk($sformatf("v%0d_lat", k), lat, exp_lat);
    end

    // Unaligned SW: check both backend writes
    req(0, 1, 0, 3'd2, 32'h1002, 64'hAABBCCDD, lat, acked);
    chk("sw_a1", la32[0], 32'h1000);
    chk("sw_m1", lm32[0], 4'b1100);
    chk("sw_d1", ld32[0], 32'hCCDD0000);
    chk("sw_a2", la32[1], 32'h1004);
    chk("sw_m2", lm32[1], 4'b0011);
    chk("sw_d2", ld32[1], 32'h0000AABB);

    // 64-bit data path
    s_wr = nwr64; s_rd = nrd64;
    req(1, 1, 0, 3'd3, 32'h2005, 64'h1122334455667788, lat, acked);
    chk("sd_nwr", nwr64 - s_wr, 2);
    chk("sd_m1", lm64[0], 8'hE0);
    chk("sd_m2", lm64[1], 8'h1F);
    req(1, 0, 0, 3'd3, 32'h2005, 64'h0, lat, acked);
    chk("ld_data", odata64, 64'h1122334455667788);
    chk("ld_nrd", nrd64 - s_rd, 2);
    chk("ld_lat", lat, 8);
    req(1, 0, 0, 3'd0, 32'h2005, 64'h0, lat, acked);
    chk("lb64_data", odata64, 64'hFFFFFFFFFFFFFF88);
    chk("lb64_nrd", nrd64 - s_rd, 3);

`ifdef DRAM_REFRESH_EN
    // Back-to-back reads: refresh can only get in once past REFRESH_MAX
    for (int i = 0; i < 60 && st32 != 8'd0; i++) @(negedge clk);
    s_ack0 = nack32;
    i_addr = 32'h1000; i_ctrl = 3'd2; rd32 = 1;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mref32) begin seen = 1; break; end
    end
    rd32 = 0;
    repeat (20) @(negedge clk);
    chk("ref_seen", seen, 1);
    chk("ref_reads_before", (nack32 - s_ack0) > 0, 1);
    chk("ref_late", late32, 1);
`else
    chk("no_refresh", nrefobs, 0);
    chk("no_late", late32 | late64, 0);
`endif

    // Reset in the middle of the second write
    @(negedge clk);
    i_addr = 32'h1002; i_ctrl = 3'd2; i_data = 64'hAABBCCDD; wr32 = 1;
    acked = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack32) begin acked = 1; break; end
    end
    chk("t_ack", acked, 1);
    chk("t_wr_with_ack", mwr32, 1);
    chk("t_addr", maddr32, 32'h1000);
    wr32 = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (st32 == 8'd8) begin seen = 1; break; end
      @(negedge clk);
    end
    chk("wr2_wait_reached", seen, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_state", st32, 8'd0);
    chk("mid_rst_req", {mrd32, mwr32, mref32}, 0);
    chk("mid_rst_data", odata32, 0);
    chk("mid_rst_late", late32, 0);
    s_rd = nrd32;
    req(0, 0, 0, 3'd2, 32'h1000, 64'h0, lat, acked);
    chk("post_rst_acked", acked, 1);
    chk("post_rst_data", odata32, 32'hCCDD8011);
    chk("post_rst_nrd", nrd32 - s_rd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_split_access_ctrl.md
# dram_split_access_ctrl

Parametrised front-end between the CPU bus and the SDRAM memory controller. It turns one load or store of 1/2/4/8 bytes at any byte address into one or two aligned backend transactions on a DATA_W-wide memory, with byte masks, sign/zero extension and an explicit accept pulse. Optionally, it schedules periodic refresh around CPU traffic. It is the DATA_W-generic successor of the 32-bit DRAM_conRV access path and sits directly above MemoryController.

## Interface
- DATA_W, 32: backend and user data width; 32 or 64. B = DATA_W/8 bytes per word.
- ADDR_W, 32: byte address width.
- REFRESH_CNT, 200: cycles after which a refresh becomes eligible.
- REFRESH_MAX, 405: cycles after which a refresh is forced ahead of CPU requests.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- i_rd_en  in  1  load request.
- i_wr_en  in  1  store request.
- i_addr  in  ADDR_W  byte address.
- i_data  in  DATA_W  store data, right-justified.
- i_ctrl  in  3  [1:0] size code (0=B, 1=H, 2=W, 3=D); [2] 1 = unsigned load.
- o_ack  out  1  one-cycle pulse when a request is accepted.
- o_done  out  1  one-cycle pulse when the access completes.
- o_err  out  1  one-cycle pulse together with o_done for an illegal size.
- o_data  out  DATA_W  load result; held until the next load completes.
- o_busy  out  1  = stall | i_m_busy.
- o_state  out  8  current FSM state code (debug).
- o_m_rd, o_m_wr, o_m_refresh  out  1  backend requests.
- o_m_addr  out  ADDR_W  word-aligned backend address.
- o_m_wdata  out  DATA_W  backend write data.
- o_m_mask  out  B  byte enables, active-high.
- i_m_rdata  in  DATA_W  backend read data.
- i_m_busy  in  1  backend busy.
- o_late_refresh  out  1  sticky flag: a refresh started later than REFRESH_MAX.

## Operation
- States: IDLE, RD1_REQ, RD1_WAIT, RD2_REQ, RD2_WAIT, WR1_REQ, WR1_WAIT, WR2_REQ, WR2_WAIT, DONE, REF_REQ, REF_WAIT.
- Accept condition: state is IDLE and i_m_busy=0. If i_rd_en and i_wr_en are both high, the read wins; the write is not acked.
- Capture: addr, data and ctrl are sampled only on the accept edge. The requester drops its enable on o_ack.
- Access split:
  - n = 1<<size; off = addr mod B; word address WA = addr with the low log2(B) bits cleared.
  - The access splits into two transactions iff off + n > B. The second transaction uses address WA + B.
- Write masks and data:
  - mask1 = ((1<<n)-1) << off, truncated to B bits; wdata1 = data << 8·off.
  - mask2 = ((1<<n)-1) >> (B−off); wdata2 = data >> 8·(B−off).
- Read data:
  - Result = ({rd2, rd1} >> 8·off), low n bytes kept.
  - Sign-extended unless i_ctrl[2]=1; size 3 is never extended.
  - rd2 is treated as 0 when only one read is issued.
- Backend handshake (each xx_REQ state):
  - The request is held high until the first cycle with i_m_busy=1, then goes low and the FSM enters xx_WAIT.
  - xx_WAIT ends on i_m_busy=0: the FSM moves to the second REQ state or to DONE.
- DONE: o_done=1 for one cycle, then IDLE. A load updates o_data at the DONE entry edge.
- Illegal size: size code 3 with DATA_W=32. The request is acked, DONE follows directly with o_err=1, no backend access is made, and o_data is set to 0.
- Stall: internal stall is high from the accept edge until the DONE→IDLE edge.
- Reset values:
  - All request outputs, o_ack, o_done, o_err and o_late_refresh are 0.
  - o_data is 0; state is IDLE; o_m_mask is 0.
- Reset mid-operation: the FSM returns to IDLE and request outputs drop on the same edge. The in-flight backend transaction is abandoned. The next accept still waits for i_m_busy=0.

## Timing
- Accept at edge T0: o_ack is high during cycle T0+1, and o_m_rd/o_m_wr are high from T0+1.
- With a backend that raises busy 1 cycle after a request and holds it for L cycles, a single transaction lasts L+2 cycles from request to done. A split access adds L+2 more.
- At least one IDLE cycle separates consecutive accesses.
- o_m_addr, o_m_wdata and o_m_mask are stable while the corresponding request is high.

## Configuration
- DRAM_REFRESH_EN defined:
  - A free-running counter increments every cycle and clears on REF_WAIT exit.
  - In IDLE with i_m_busy=0: if the count exceeds REFRESH_MAX, refresh has priority over requests; if it exceeds REFRESH_CNT and no request is present, refresh is issued.
  - o_m_refresh follows the same REQ/WAIT handshake.
  - o_late_refresh is set when a refresh starts with count > REFRESH_MAX.
- DRAM_REFRESH_EN not defined: no counter is built; o_m_refresh=0 and o_late_refresh=0 always.

## Test plan
- DATA_W=32, words [0x1000]=0x44332211 and [0x1004]=0x88776655; LW at 0x1003 → two reads, o_data=0x77665544, one o_done.
- LB signed at 0x1001 with byte 0x80 → o_data=0xFFFFFF80; the same access as LBU → 0x00000080; exactly one backend read.
- SW 0xAABBCCDD at 0x1002 → write 1: addr 0x1000, mask 1100, wdata 0xCCDD0000; write 2: addr 0x1004, mask 0011, wdata 0x0000AABB.
- DATA_W=64, SD 0x1122334455667788 at 0x2005 → mask1 0xE0, mask2 0x1F; a readback LD at 0x2005 returns the same value.
- DATA_W=32, i_ctrl size 3 → o_ack, then o_done with o_err=1, no o_m_rd/o_m_wr pulse.
- DRAM_REFRESH_EN, REFRESH_CNT=20, REFRESH_MAX=40, CPU reads held back-to-back → refresh preempts at count 41 and o_late_refresh=1. rst asserted mid-WR2_WAIT → IDLE next edge and all requests low.
